// File: rtl/s_pg_rca_seq_pkg.sv
// Shared types and constants for the chunked signed add/subtract sequencer.
// The optional overflow flag in the top is built only when S_PG_RCA_SEQ_OVF_EN is defined.
package s_pg_rca_seq_pkg;

  localparam int DEF_CHUNK_W    = 24;
  localparam int DEF_NUM_CHUNKS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The chunk index register is never narrower than one bit, even for NUM_CHUNKS=1.
  function automatic int idx_w(input int num_chunks);
    return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
  endfunction

endpackage

// File: rtl/s_pg_rca_multiword_seq_pg_rca_chunk.sv
// CHUNK_W-bit unsigned ripple-carry adder slice.
// Each bit uses propagate/generate cells, and the carries are merged with and/or logic.
module pg_rca_chunk #(
  parameter int CHUNK_W = 24
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] s_o,
  output logic               cout_o
);

  logic [CHUNK_W-1:0] p;
  logic [CHUNK_W-1:0] g;
  logic [CHUNK_W:0]   c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
    assign p[i]   = a_i[i] ^ b_i[i];
    assign g[i]   = a_i[i] & b_i[i];
    assign c[i+1] = g[i] | (p[i] & c[i]);
    assign s_o[i] = p[i] ^ c[i];
  end

  assign cout_o = c[CHUNK_W];

endmodule

// File: rtl/s_pg_rca_multiword_seq.sv
// Wide signed add/subtract that reuses one CHUNK_W slice, working LSB chunk first.
// Define S_PG_RCA_SEQ_OVF_EN to add the registered ovf output.
module s_pg_rca_multiword_seq
  import s_pg_rca_seq_pkg::*;
#(
  parameter int CHUNK_W    = DEF_CHUNK_W,
  parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0]   a,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0]   b,
  input  logic                            sub,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHUNK_W*NUM_CHUNKS:0]     sum,
`ifdef S_PG_RCA_SEQ_OVF_EN
  output logic                            ovf,
`endif
  output logic                            busy,
  output logic [1:0]                      dbg_state_o
);

  // Handshake: a transfer happens on a rising edge when valid and ready are both high.
  // in_ready and out_valid come only from registered state.
  localparam int W  = CHUNK_W * NUM_CHUNKS;
  localparam int IW = idx_w(NUM_CHUNKS);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       a_q;
  logic [W-1:0]       bm_q;
  logic [W:0]         sum_q;
  logic               carry_q;
  logic [IW-1:0]      idx_q;
  logic [CHUNK_W-1:0] a_ch, b_ch, s_ch;
  logic               cout;
  logic               last_chunk;
  logic               ext_bit;

  assign a_ch       = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign b_ch       = bm_q[idx_q*CHUNK_W +: CHUNK_W];
  assign last_chunk = (idx_q == LAST_IDX);
  assign ext_bit    = a_q[W-1] ^ bm_q[W-1] ^ cout;

  pg_rca_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a_i    (a_ch),
    .b_i    (b_ch),
    .cin_i  (carry_q),
    .s_o    (s_ch),
    .cout_o (cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      bm_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
        a_q     <= a;
        bm_q    <= b ^ {W{sub}};
        carry_q <= sub;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sum_q[idx_q*CHUNK_W +: CHUNK_W] <= s_ch;
        carry_q                         <= cout;
        if (last_chunk) begin
          sum_q[W] <= ext_bit;
          idx_q    <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef S_PG_RCA_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_RUN && last_chunk) begin
      ovf_q <= ext_bit ^ s_ch[CHUNK_W-1];
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum         = sum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_s_pg_rca_multiword_seq.sv
// Directed bench for s_pg_rca_multiword_seq at the default 4 x 24-bit configuration.
// It uses a vector table plus hand-written sequences for backpressure and mid-run reset.
module tb_s_pg_rca_multiword_seq;

  localparam int W = 96;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   exp_sum;
    logic         exp_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef S_PG_RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  s_pg_rca_multiword_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
`ifdef S_PG_RCA_SEQ_OVF_EN
    .ovf         (ovf),
`endif
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Driver: caller is #1 after a rising edge with the DUT idle; returns with out_valid observed
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                      input string nm, output int lat);
    a = ta; b = tb; sub = tsub; in_valid = 1'b1;
    chk({nm, " in_ready before accept"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({nm, " busy/in_ready in RUN"}, {126'd0, busy, in_ready}, 128'b10);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, " idle after out_ready"}, {125'd0, out_valid, in_ready, busy}, 128'b010);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    logic [W:0] held;

    vecs[0] = '{96'd1, {96{1'b1}}, 1'b0, 97'd0, 1'b0};
    vecs[1] = '{96'h00FF_FFFF, 96'd1, 1'b0, 97'h100_0000, 1'b0};
    vecs[2] = '{{1'b0, {95{1'b1}}}, 96'd1, 1'b0, {1'b0, 1'b1, 95'd0}, 1'b1};
    vecs[3] = '{96'd5, 96'd7, 1'b1, {{96{1'b1}}, 1'b0}, 1'b0};
    vecs[4] = '{{1'b1, 95'd0}, 96'd1, 1'b1, {1'b1, 1'b0, {95{1'b1}}}, 1'b1};
    vecs[5] = '{{96{1'b1}}, {96{1'b1}}, 1'b0, {{96{1'b1}}, 1'b0}, 1'b0};
    vecs[6] = '{{1'b1, 95'd0}, {1'b1, 95'd0}, 1'b0, {1'b1, 96'd0}, 1'b1};
    vecs[7] = '{96'd3, 96'd4, 1'b0, 97'd7, 1'b0};
    vecs[8] = '{96'd0, 96'd0, 1'b1, 97'd0, 1'b0};

    // Reset values while rst_n is held low
    #12;
    chk("reset outputs", {124'd0, in_ready, out_valid, busy, 1'b0}, 128'b1000);
    chk("reset sum", 128'(sum), 128'd0);
    chk("reset state", 128'(dbg_state), 128'd0);
`ifdef S_PG_RCA_SEQ_OVF_EN
    chk("reset ovf", 128'(ovf), 128'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
      chk($sformatf("vec%0d sum", i), 128'(sum), 128'(vecs[i].exp_sum));
      chk($sformatf("vec%0d busy in DONE", i), 128'(busy), 128'd1);
`ifdef S_PG_RCA_SEQ_OVF_EN
      chk($sformatf("vec%0d ovf", i), 128'(ovf), 128'(vecs[i].exp_ovf));
`endif
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: DONE held for 10 cycles while a new request waits
    send(96'd10, 96'd20, 1'b0, "hold", lat);
    chk("hold latency", 128'(lat), 128'd4);
    held = sum;
    chk("hold sum", 128'(held), 128'd30);
    a = 96'd100; b = 96'd200; sub = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 chk($sformatf("hold cycle%0d", c), {sum, out_valid, in_ready}, {held, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold back to idle", {126'd0, out_valid, in_ready}, 128'b01);
    chk("hold sum kept in idle", 128'(sum), 128'd30);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("hold new accept", 128'(busy), 128'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("hold new latency", 128'(lat), 128'd4);
    chk("hold new sum", 128'(sum), 128'd300);
    release_result("hold new");

    // Asynchronous reset after two RUN cycles
    a = {96{1'b1}}; b = 96'd5; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("partial sum nonzero", 128'(sum != '0), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun reset outputs", {125'd0, in_ready, out_valid, busy}, 128'b100);
    chk("midrun reset sum", 128'(sum), 128'd0);
    chk("midrun reset state", 128'(dbg_state), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(96'd3, 96'd4, 1'b0, "post reset", lat);
    chk("post reset latency", 128'(lat), 128'd4);
    chk("post reset sum", 128'(sum), 128'd7);
    release_result("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
